// File: rtl/fetch_pkg.sv
// Shared types and RV32 predecode helpers for the multi-lane fetch unit.
package fetch_pkg;

  localparam int ILEN = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_t;

  typedef struct packed {
    logic            is_jal;
    logic            is_jalr;
    logic            is_br;
    logic [ILEN-1:0] imm;
  } lane_pd_t;

  // Sign-extended immediate in the format implied by the opcode; I-type otherwise.
  function automatic logic [ILEN-1:0] decode_imm(input logic [ILEN-1:0] ins);
    case (ins[6:0])
      OP_JAL:          return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      OP_BRANCH:       return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_STORE:        return {{21{ins[31]}}, ins[30:25], ins[11:7]};
      OP_LUI, OP_AUIPC: return {ins[31:12], 12'b0};
      default:         return {{21{ins[31]}}, ins[30:20]};
    endcase
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Single-lane combinational predecoder: control-transfer class and immediate.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [ILEN-1:0] i_instr,
  output lane_pd_t        o_pd
);

  always_comb begin
    o_pd         = '0;
    o_pd.is_jal  = (i_instr[6:0] == OP_JAL);
    o_pd.is_jalr = (i_instr[6:0] == OP_JALR);
    o_pd.is_br   = (i_instr[6:0] == OP_BRANCH);
    o_pd.imm     = decode_imm(i_instr);
  end

endmodule

// File: rtl/multi_fetch_param.sv
// N-lane fetch front end: PC, predecode, group truncation and a one-deep output stage.
// Build option: define STATIC_BTFN_EN to predict backward branches taken.
module multi_fetch_param
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              LANES    = 3,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [LANES*XLEN-1:0] inst_addr_o,
  input  logic [LANES*XLEN-1:0] instruction_i,
  input  logic                  flush_i,
  input  logic                  buble_i,
  input  logic                  redirect_valid_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  output logic [LANES-1:0]      fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic [LANES*XLEN-1:0] pc_o,
  output logic [LANES*XLEN-1:0] instruction_o,
  output logic [LANES*XLEN-1:0] imm_o,
  output logic [LANES-1:0]      pred_taken_o
);

`ifdef STATIC_BTFN_EN
  localparam logic BTFN_ON = 1'b1;
`else
  localparam logic BTFN_ON = 1'b0;
`endif

  fetch_state_t          r_state, w_state_nxt;
  logic [XLEN-1:0]       r_pc;
  logic [LANES-1:0]      r_valid, r_taken;
  logic [LANES*XLEN-1:0] r_pc_l, r_instr, r_imm;

  logic [XLEN-1:0]       w_lane_pc [LANES];
  logic [XLEN-1:0]       w_imm     [LANES];
  lane_pd_t              w_pd      [LANES];
  logic [LANES-1:0]      w_taken, w_term, w_grp_valid, w_grp_taken;
  logic [LANES*XLEN-1:0] w_grp_pc, w_grp_instr, w_grp_imm;
  logic [XLEN-1:0]       w_next_pc;
  logic                  w_capture, w_transfer;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_pc[g] = r_pc + XLEN'(4 * g);

    fetch_predecode u_pd (
      .i_instr (instruction_i[g*XLEN +: ILEN]),
      .o_pd    (w_pd[g])
    );

    assign w_imm[g]   = XLEN'($signed(w_pd[g].imm));
    assign w_taken[g] = w_pd[g].is_jal | (BTFN_ON & w_pd[g].is_br & w_pd[g].imm[ILEN-1]);
    assign w_term[g]  = w_taken[g] | w_pd[g].is_jalr;

    // Address bus reads as zero while reset is held low.
    assign inst_addr_o[g*XLEN +: XLEN] = reset ? w_lane_pc[g] : '0;

    assign w_grp_pc[g*XLEN +: XLEN]    = w_grp_valid[g] ? w_lane_pc[g] : '0;
    assign w_grp_instr[g*XLEN +: XLEN] = w_grp_valid[g] ? instruction_i[g*XLEN +: XLEN] : '0;
    assign w_grp_imm[g*XLEN +: XLEN]   = w_grp_valid[g] ? w_imm[g] : '0;
  end

  // Lanes up to and including the first terminator are kept; that lane picks next_pc.
  always_comb begin
    logic found;
    // NOTE: blocking assignments in combinational logic, with every output defaulted first so no latch is inferred.
    found       = 1'b0;
    w_grp_valid = '0;
    w_grp_taken = '0;
    w_next_pc   = r_pc + XLEN'(4 * LANES);
    for (int i = 0; i < LANES; i++) begin
      if (!found) begin
        w_grp_valid[i] = 1'b1;
        if (w_term[i]) begin
          found          = 1'b1;
          w_grp_taken[i] = w_taken[i];
          w_next_pc      = w_taken[i] ? w_lane_pc[i] + w_imm[i] : w_lane_pc[i] + XLEN'(4);
        end
      end
    end
  end

  assign w_transfer = r_valid[0] & fetch_ready_i;
  assign w_capture  = (r_state != BOOT) & ~buble_i & ~flush_i & ~redirect_valid_i
                    & (~r_valid[0] | fetch_ready_i);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     if (r_valid[0] & ~fetch_ready_i) w_state_nxt = HOLD;
      HOLD:    if (fetch_ready_i) w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
    if (redirect_valid_i) w_state_nxt = RUN;
  end

  // NOTE: sequential state uses non-blocking assignments and clears asynchronously on reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_valid <= '0;
      r_taken <= '0;
      r_pc_l  <= '0;
      r_instr <= '0;
      r_imm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid_i) r_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
      else if (w_capture)   r_pc <= w_next_pc;

      if (redirect_valid_i | flush_i | (w_transfer & ~w_capture)) begin
        r_valid <= '0;
        r_taken <= '0;
        r_pc_l  <= '0;
        r_instr <= '0;
        r_imm   <= '0;
      end else if (w_capture) begin
        r_valid <= w_grp_valid;
        r_taken <= w_grp_taken;
        r_pc_l  <= w_grp_pc;
        r_instr <= w_grp_instr;
        r_imm   <= w_grp_imm;
      end
    end
  end

  assign fetch_valid_o = r_valid;
  assign pred_taken_o  = r_taken;
  assign pc_o          = r_pc_l;
  assign instruction_o = r_instr;
  assign imm_o         = r_imm;

endmodule

// File: tb/tb_multi_fetch_param.sv
// Self-checking bench for multi_fetch_param: directed scenarios then randomized traffic against a group-level model.
module tb_multi_fetch_param;

  localparam int          XLEN  = 32;
  localparam int          LANES = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef STATIC_BTFN_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [LANES*XLEN-1:0] inst_addr_o, instruction_i, pc_o, instruction_o, imm_o;
  logic                  flush = 1'b0, bub = 1'b0, redir = 1'b0, ready = 1'b0;
  logic [XLEN-1:0]       rpc = '0;
  logic [LANES-1:0]      fetch_valid_o, pred_taken_o;

  multi_fetch_param #(.XLEN(XLEN), .LANES(LANES), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_addr_o      (inst_addr_o),
    .instruction_i    (instruction_i),
    .flush_i          (flush),
    .buble_i          (bub),
    .redirect_valid_i (redir),
    .redirect_pc_i    (rpc),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_ready_i    (ready),
    .pc_o             (pc_o),
    .instruction_o    (instruction_o),
    .imm_o            (imm_o),
    .pred_taken_o     (pred_taken_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  logic [31:0] prog [logic [31:0]];
  logic [31:0] rom  [64];
  bit          rand_mode = 1'b0;

  bit               m_booted;
  logic [31:0]      m_pc;
  logic [LANES-1:0] m_valid, m_taken;
  logic [31:0]      m_lpc [LANES];
  logic [31:0]      m_ins [LANES];
  logic [31:0]      m_imm [LANES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] lane(input logic [LANES*XLEN-1:0] v, input int i);
    return v[i*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    if (rand_mode) return rom[a[7:2]];
    return NOP;
  endfunction

  // Immediate value from the ISA bit layout, built as a signed integer sum.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'b1101111: v = (ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12)
                    + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
      7'b1100011: v = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11)
                    + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
      7'b0100011: v = (ins[31] ? -2048 : 0) + (int'(ins[30:25]) << 5) + int'(ins[11:7]);
      7'b0110111, 7'b0010111: v = int'(ins & 32'hFFFF_F000);
      default:    v = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] enc_jal(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_br(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [31:0] imm);
    return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  task automatic model_clear();
    m_valid = '0;
    m_taken = '0;
    for (int i = 0; i < LANES; i++) begin
      m_lpc[i] = '0; m_ins[i] = '0; m_imm[i] = '0;
    end
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_pc     = 32'h0;
    model_clear();
  endtask

  // Walk the lanes from the model PC, stopping after the first taken jump or JALR.
  task automatic model_fetch();
    logic [31:0] npc, pc, ins;
    bit          tk;
    npc = m_pc + 32'(4 * LANES);
    model_clear();
    for (int i = 0; i < LANES; i++) begin
      pc  = m_pc + 32'(4 * i);
      ins = mem_word(pc);
      m_valid[i] = 1'b1;
      m_lpc[i]   = pc;
      m_ins[i]   = ins;
      m_imm[i]   = ref_imm(ins);
      tk = (ins[6:0] == 7'b1101111) || (BTFN && ins[6:0] == 7'b1100011 && $signed(m_imm[i]) < 0);
      if (tk) begin
        m_taken[i] = 1'b1;
        npc = pc + m_imm[i];
        break;
      end
      if (ins[6:0] == 7'b1100111) begin
        npc = pc + 32'd4;
        break;
      end
    end
    m_pc = npc;
  endtask

  task automatic model_step();
    bit xfer, can;
    xfer = m_valid[0] && ready;
    can  = m_booted;
    m_booted = 1'b1;
    if (redir) begin
      m_pc = rpc & ~32'h3;
      model_clear();
    end else if (flush) begin
      model_clear();
    end else if (can && !bub && (!m_valid[0] || ready)) begin
      model_fetch();
    end else if (xfer) begin
      model_clear();
    end
  endtask

  task automatic drive_imem();
    for (int i = 0; i < LANES; i++)
      instruction_i[i*XLEN +: XLEN] = mem_word(lane(inst_addr_o, i));
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s.valid", tag), 32'(fetch_valid_o), 32'(m_valid));
    check($sformatf("%s.taken", tag), 32'(pred_taken_o), 32'(m_taken));
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("%s.pc%0d", tag, i),   lane(pc_o, i),          m_lpc[i]);
      check($sformatf("%s.ins%0d", tag, i),  lane(instruction_o, i), m_ins[i]);
      check($sformatf("%s.imm%0d", tag, i),  lane(imm_o, i),         m_imm[i]);
      check($sformatf("%s.addr%0d", tag, i), lane(inst_addr_o, i),   m_pc + 32'(4 * i));
    end
  endtask

  task automatic tick(input string tag);
    drive_imem();
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic fill_rom();
    int          r;
    logic [31:0] imm;
    for (int i = 0; i < 64; i++) begin
      r   = int'($urandom_range(0, 9));
      imm = 32'((int'($urandom_range(0, 127)) - 64) * 4);
      case (r)
        0:       rom[i] = enc_jal(imm);
        1:       rom[i] = enc_br(imm);
        2:       rom[i] = enc_jalr(imm);
        3:       rom[i] = ($urandom & ~32'h7F) | 32'h37;
        4:       rom[i] = ($urandom & ~32'h7F) | 32'h23;
        default: rom[i] = ($urandom & ~32'h7F) | 32'h13;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    instruction_i = '0;
    model_reset();

    // Reset state while reset is held low.
    #12;
    check("rst.valid", 32'(fetch_valid_o), 32'h0);
    check("rst.taken", 32'(pred_taken_o), 32'h0);
    check("rst.addr1", lane(inst_addr_o, 1), 32'h0);
    check("rst.pc0",   lane(pc_o, 0), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    ready = 1'b1;

    // 1: sequential NOPs.
    tick("boot");
    check("boot.novalid", 32'(fetch_valid_o), 32'h0);
    tick("t1a");
    check("t1a.pc0", lane(pc_o, 0), 32'h0);
    check("t1a.valid", 32'(fetch_valid_o), 32'h7);
    tick("t1b");
    check("t1b.pc0", lane(pc_o, 0), 32'h0C);
    tick("t1c");
    check("t1c.pc0", lane(pc_o, 0), 32'h18);

    // 2: JAL +0x40 in lane 1 of the group at 0x100.
    prog[32'h104] = enc_jal(32'h40);
    redir = 1'b1; rpc = 32'h100;
    tick("t2redir");
    redir = 1'b0;
    tick("t2grp");
    check("t2.valid", 32'(fetch_valid_o), 32'h3);
    check("t2.taken", 32'(pred_taken_o), 32'h2);
    check("t2.imm1",  lane(imm_o, 1), 32'h40);
    tick("t2next");
    check("t2.nextpc", lane(pc_o, 0), 32'h144);

    // 3: back-pressure holds the group and the PC.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("t3hold");
      check("t3.pc0",  lane(pc_o, 0), 32'h144);
      check("t3.addr", lane(inst_addr_o, 0), 32'h150);
    end
    ready = 1'b1;
    tick("t3rel");
    check("t3.after", lane(pc_o, 0), 32'h150);

    // 4: redirect wins over flush and bubble; bits [1:0] dropped.
    redir = 1'b1; rpc = 32'h2002; flush = 1'b1; bub = 1'b1;
    tick("t4redir");
    check("t4.clear", 32'(fetch_valid_o), 32'h0);
    redir = 1'b0; flush = 1'b0; bub = 1'b0;
    tick("t4grp");
    check("t4.pc0", lane(pc_o, 0), 32'h2000);

    // 5: backward BEQ (imm -8) in lane 0 at 0x200.
    prog[32'h200] = enc_br(32'hFFFF_FFF8);
    redir = 1'b1; rpc = 32'h200;
    tick("t5redir");
    redir = 1'b0;
    tick("t5grp");
    check("t5.imm0", lane(imm_o, 0), 32'hFFFF_FFF8);
    if (BTFN) begin
      check("t5.valid", 32'(fetch_valid_o), 32'h1);
      check("t5.taken", 32'(pred_taken_o), 32'h1);
      check("t5.next",  lane(inst_addr_o, 0), 32'h1F8);
    end else begin
      check("t5.valid", 32'(fetch_valid_o), 32'h7);
      check("t5.taken", 32'(pred_taken_o), 32'h0);
      check("t5.next",  lane(inst_addr_o, 0), 32'h20C);
    end
    tick("t5after");

    // 6: address wrap at the top of the space.
    redir = 1'b1; rpc = 32'hFFFF_FFF8;
    tick("t6redir");
    redir = 1'b0;
    check("t6.addr0", lane(inst_addr_o, 0), 32'hFFFF_FFF8);
    check("t6.addr1", lane(inst_addr_o, 1), 32'hFFFF_FFFC);
    check("t6.addr2", lane(inst_addr_o, 2), 32'h0);
    tick("t6grp");
    check("t6.pc2",  lane(pc_o, 2), 32'h0);
    check("t6.next", lane(inst_addr_o, 0), 32'h4);

    // 6b: asynchronous reset while a group is held.
    ready = 1'b0;
    tick("t6hold");
    #2;
    reset = 1'b0;
    #1;
    check("t6rst.valid", 32'(fetch_valid_o), 32'h0);
    check("t6rst.pc0",   lane(pc_o, 0), 32'h0);
    check("t6rst.addr0", lane(inst_addr_o, 0), 32'h0);
    model_reset();
    ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick("t6boot");
    check("t6boot.valid", 32'(fetch_valid_o), 32'h0);
    tick("t6restart");
    check("t6restart.pc0", lane(pc_o, 0), 32'h0);

    // Randomized traffic over a random instruction image.
    prog.delete();
    fill_rom();
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      bub   = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 19) == 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = $urandom_range(0, 1023);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
